// File: rtl/ad9228_tx_emulator.sv
// Emulates the serial LVDS output of one AD9228 channel: MSB-first data with a
// DDR bit clock (dco) and frame clock (fco); sources are stream, fixed, ramp or checkerboard.
module ad9228_tx_emulator #(
   parameter int DATA_WIDTH   = 12,
   parameter bit DIN_INVERTED = 1'b0,
   parameter bit DCO_INVERTED = 1'b0,
   parameter bit FCO_INVERTED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic [1:0]            mode_i,
   input  logic [DATA_WIDTH-1:0] pattern_i,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  din_o,
   output logic                  dco_o,
   output logic                  fco_o,
   output logic                  busy_o,
   output logic                  underflow_o,
   output logic [15:0]           frame_cnt_o
);

   // state | meaning
   // IDLE  | no frame in flight, pins at idle level, b held at 0
   // RUN   | shifting one bit per clk, b = bit index within frame

   localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] B_HALF = BW'(DATA_WIDTH / 2);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // phase 0 gives ...1010 (0xAAA at 12 bits), phase 1 its complement
   function automatic logic [DATA_WIDTH-1:0] cb_word(input logic phase);
      logic [DATA_WIDTH-1:0] w;
      for (int i = 0; i < DATA_WIDTH; i++) w[i] = ((i % 2) == 1) ^ phase;
      return w;
   endfunction

   state_t                state_q, state_d;
   logic [BW-1:0]         b_q, b_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
   logic                  cb_q, cb_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  underflow_q, underflow_d;
   logic                  din_q, din_d;
   logic                  dco_q, dco_d;
   logic                  fco_q, fco_d;
   logic                  frame_start;

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      last_d      = last_q;
      ramp_d      = ramp_q;
      cb_d        = cb_q;
      frame_cnt_d = frame_cnt_q;
      underflow_d = 1'b0;
      frame_start = 1'b0;

      if (s_valid && !hold_full_q) begin
         hold_d      = s_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            b_d = '0;
            if (enable_i) frame_start = 1'b1;
         end
         RUN: begin
            if (b_q == B_LAST) begin
               if (enable_i) begin
                  frame_start = 1'b1;
               end else begin
                  state_d = IDLE;
                  b_d     = '0;
               end
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            b_d     = '0;
         end
      endcase

      if (frame_start) begin
         state_d     = RUN;
         b_d         = '0;
         frame_cnt_d = frame_cnt_q + 16'd1;
         case (mode_i)
            2'b00: begin
               // hold_full_q set means no capture this cycle, so clearing here cannot race it
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  last_d      = hold_q;
                  hold_full_d = 1'b0;
               end else begin
                  shift_d     = last_q;
                  underflow_d = 1'b1;
               end
            end
            2'b01: shift_d = pattern_i;
            2'b10: begin
               shift_d = ramp_q;
               ramp_d  = ramp_q + 1'b1;
            end
            default: begin
               shift_d = cb_word(cb_q);
               cb_d    = ~cb_q;
            end
         endcase
      end

      // pins are computed from next state so they line up with b in the same cycle
      din_d = (state_d == RUN) & shift_d[B_LAST - b_d];
      dco_d = (state_d == RUN) & b_d[0];
      fco_d = (state_d == RUN) & (b_d < B_HALF);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         b_q         <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         last_q      <= '0;
         ramp_q      <= '0;
         cb_q        <= 1'b0;
         frame_cnt_q <= '0;
         underflow_q <= 1'b0;
         din_q       <= 1'b0;
         dco_q       <= 1'b0;
         fco_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         last_q      <= last_d;
         ramp_q      <= ramp_d;
         cb_q        <= cb_d;
         frame_cnt_q <= frame_cnt_d;
         underflow_q <= underflow_d;
         din_q       <= din_d;
         dco_q       <= dco_d;
         fco_q       <= fco_d;
      end
   end

   assign din_o       = din_q ^ DIN_INVERTED;
   assign dco_o       = dco_q ^ DCO_INVERTED;
   assign fco_o       = fco_q ^ FCO_INVERTED;
   assign busy_o      = (state_q == RUN);
   assign s_ready     = ~hold_full_q;
   assign underflow_o = underflow_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_ad9228_tx_emulator.sv
// Directed bench for ad9228_tx_emulator: serial framing, sources, enable/reset behaviour
// and pin inversion, against hand-computed words.
module tb_ad9228_tx_emulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0;
   logic [1:0]  mode_i = 2'b00;
   logic [11:0] pattern_i = '0;
   logic [11:0] s_data = '0;
   logic        s_valid = 1'b0;

   logic        s_ready, din_o, dco_o, fco_o, busy_o, underflow_o;
   logic [15:0] frame_cnt_o;
   logic        s_ready_n, din_n, dco_n, fco_n, busy_n, underflow_n;
   logic [15:0] frame_cnt_n;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ad9228_tx_emulator dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .mode_i(mode_i), .pattern_i(pattern_i),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .din_o(din_o), .dco_o(dco_o),
      .fco_o(fco_o), .busy_o(busy_o), .underflow_o(underflow_o), .frame_cnt_o(frame_cnt_o)
   );

   ad9228_tx_emulator #(.DIN_INVERTED(1'b1)) dut_inv (
      .clk(clk), .rst(rst), .enable_i(enable_i), .mode_i(mode_i), .pattern_i(pattern_i),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_n), .din_o(din_n), .dco_o(dco_n),
      .fco_o(fco_n), .busy_o(busy_n), .underflow_o(underflow_n), .frame_cnt_o(frame_cnt_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable_i = 1'b0; s_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // samples one 12-bit frame starting at b=0; enable drops after sampling bit drop_at
   task automatic cap(input int drop_at, input bit inv, output logic [11:0] w,
                      output logic [11:0] fv, output logic [11:0] dv,
                      output int uf, output int bz);
      w = '0; fv = '0; dv = '0; uf = 0; bz = 0;
      for (int i = 0; i < 12; i++) begin
         w  = {w[10:0],  inv ? din_n : din_o};
         fv = {fv[10:0], inv ? fco_n : fco_o};
         dv = {dv[10:0], inv ? dco_n : dco_o};
         uf += int'(underflow_o);
         bz += int'(busy_o);
         if (i == drop_at) enable_i = 1'b0;
         tick();
      end
   endtask

   logic [11:0] w, fv, dv, w2, fv2, dv2;
   int uf, bz, uf2, bz2, bad_words;

   initial begin
      do_reset();
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_pins", {29'd0, din_o, dco_o, fco_o}, 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      chk("rst_inv_din_idle", 32'(din_n), 32'd1);

      // stream 0xA5C then 0x123, back to back
      mode_i = 2'b00; s_data = 12'hA5C; s_valid = 1'b1;
      tick();
      chk("str_s_ready_full", 32'(s_ready), 32'd0);
      s_data = 12'h123; enable_i = 1'b1;
      tick();
      chk("str_s_ready_after_load", 32'(s_ready), 32'd1);
      cap(-1, 1'b0, w, fv, dv, uf, bz);
      s_valid = 1'b0;
      cap(0, 1'b0, w2, fv2, dv2, uf2, bz2);
      chk("str_din", {8'd0, w, w2}, {8'd0, 24'hA5C123});
      chk("str_fco", {8'd0, fv, fv2}, {8'd0, 24'hFC0FC0});
      chk("str_dco", {8'd0, dv, dv2}, {8'd0, 24'h555555});
      chk("str_underflow", 32'(uf + uf2), 32'd0);
      chk("str_busy_cycles", 32'(bz + bz2), 32'd24);
      chk("str_frame_cnt", 32'(frame_cnt_o), 32'd2);
      chk("str_idle_busy", 32'(busy_o), 32'd0);

      // single sample then underflow repeats it
      do_reset();
      mode_i = 2'b00; s_data = 12'h800; s_valid = 1'b1;
      tick();
      s_valid = 1'b0; enable_i = 1'b1;
      tick();
      cap(-1, 1'b0, w, fv, dv, uf, bz);
      chk("uf_pulse_at_frame2", 32'(underflow_o), 32'd1);
      cap(0, 1'b0, w2, fv2, dv2, uf2, bz2);
      chk("uf_din", {8'd0, w, w2}, {8'd0, 24'h800800});
      chk("uf_count", 32'(uf + uf2), 32'd1);

      // ramp over the full range plus wrap
      do_reset();
      mode_i = 2'b10; enable_i = 1'b1;
      tick();
      bad_words = 0;
      for (int f = 0; f < 4097; f++) begin
         cap((f == 4096) ? 0 : -1, 1'b0, w, fv, dv, uf, bz);
         if (w !== 12'(f)) bad_words++;
      end
      chk("ramp_words", 32'(bad_words), 32'd0);
      chk("ramp_wrap_word", 32'(w), 32'h000);
      chk("ramp_frame_cnt", 32'(frame_cnt_o), 32'd4097);

      // enable dropped at b=3 still completes the frame
      do_reset();
      mode_i = 2'b01; pattern_i = 12'h5A3; enable_i = 1'b1;
      tick();
      cap(3, 1'b0, w, fv, dv, uf, bz);
      chk("drop_word", 32'(w), 32'h5A3);
      chk("drop_busy_cycles", 32'(bz), 32'd12);
      chk("drop_busy_after", 32'(busy_o), 32'd0);
      chk("drop_pins_after", {29'd0, din_o, dco_o, fco_o}, 32'd0);
      tick();
      chk("drop_frame_cnt", 32'(frame_cnt_o), 32'd1);

      // reset asserted at b=7
      do_reset();
      s_data = 12'h321; s_valid = 1'b1;
      tick();
      s_valid = 1'b0; mode_i = 2'b01; pattern_i = 12'hFFF; enable_i = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("rstmid_pre_pins", {29'd0, din_o, dco_o, fco_o}, 32'd6);
      chk("rstmid_pre_s_ready", 32'(s_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("rstmid_pins", {29'd0, din_o, dco_o, fco_o}, 32'd0);
      chk("rstmid_busy", 32'(busy_o), 32'd0);
      chk("rstmid_s_ready", 32'(s_ready), 32'd1);
      chk("rstmid_frame_cnt", 32'(frame_cnt_o), 32'd0);
      enable_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rstmid_no_resume", {15'd0, busy_o, frame_cnt_o}, 32'd0);
      chk("rstmid_idle_din", 32'(din_o), 32'd0);

      // checkerboard with a mid-frame mode change
      do_reset();
      mode_i = 2'b11; enable_i = 1'b1;
      tick();
      cap(-1, 1'b0, w, fv, dv, uf, bz);
      cap(-1, 1'b0, w2, fv2, dv2, uf2, bz2);
      chk("cb_first_two", {8'd0, w, w2}, {8'd0, 24'hAAA555});
      mode_i = 2'b01; pattern_i = 12'h0F0;
      cap(-1, 1'b0, w, fv, dv, uf, bz);
      cap(0, 1'b0, w2, fv2, dv2, uf2, bz2);
      chk("cb_mode_change", {8'd0, w, w2}, {8'd0, 24'hAAA0F0});

      // inverted data pin, fixed 0xFFF
      do_reset();
      mode_i = 2'b01; pattern_i = 12'hFFF;
      chk("inv_idle", {29'd0, din_n, dco_n, fco_n}, 32'd4);
      enable_i = 1'b1;
      tick();
      cap(0, 1'b1, w, fv, dv, uf, bz);
      chk("inv_din", 32'(w), 32'h000);
      chk("inv_fco", 32'(fv), 32'hFC0);
      chk("inv_dco", 32'(dv), 32'h555);
      chk("inv_idle_after", 32'(din_n), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ad9228_tx_emulator.md
AD9228_TX_EMULATOR -- requirements
Module: ad9228_tx_emulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: sample width in bits; one frame is DATA_WIDTH serial bits.
REQ-002 SHALL have parameter DIN_INVERTED, default 0: when 1, din_o pin is inverted.
REQ-003 SHALL have parameter DCO_INVERTED, default 0: when 1, dco_o pin is inverted.
REQ-004 SHALL have parameter FCO_INVERTED, default 0: when 1, fco_o pin is inverted.
REQ-005 SHALL have port clk  input  1  bit clock; all sequential logic is on the rising edge; one serial bit per clk.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable_i  input  1  requests continuous frame transmission.
REQ-008 SHALL have port mode_i  input  2  source select: 00 stream, 01 fixed, 10 ramp, 11 checkerboard.
REQ-009 SHALL have port pattern_i  input  DATA_WIDTH  fixed-mode word.
REQ-010 SHALL have port s_data  input  DATA_WIDTH  stream sample.
REQ-011 SHALL have port s_valid  input  1  s_data valid.
REQ-012 SHALL have port s_ready  output  1  holding register empty.
REQ-013 SHALL have port din_o  output  1  serial data, MSB first.
REQ-014 SHALL have port dco_o  output  1  emulated DDR bit clock, half the clk rate.
REQ-015 SHALL have port fco_o  output  1  emulated frame clock, dco/6 for DATA_WIDTH=12.
REQ-016 SHALL have port busy_o  output  1  high while in RUN.
REQ-017 SHALL have port underflow_o  output  1  one-cycle pulse on stream underflow.
REQ-018 SHALL have port frame_cnt_o  output  16  frames started, wraps 0xFFFF->0.

Function
REQ-019 SHALL implement states IDLE and RUN; bit counter b counts 0..DATA_WIDTH-1.
REQ-020 A frame start SHALL occur on the edge ending any cycle where (IDLE and enable_i) or (RUN and b=DATA_WIDTH-1 and enable_i); it sets state RUN, b=0, loads the shift register, and increments frame_cnt_o.
REQ-021 If RUN, b=DATA_WIDTH-1 and enable_i=0, the next state SHALL be IDLE; enable_i deassertion mid-frame SHALL NOT truncate the frame.
REQ-022 In RUN, registered outputs SHALL be: din_o=shift[DATA_WIDTH-1-b], dco_o=b[0], fco_o=(b<DATA_WIDTH/2); the first MSB appears the cycle after the frame-start edge.
REQ-023 In IDLE, din_o, dco_o and fco_o SHALL be 0 before inversion; b SHALL be held at 0.
REQ-024 Polarity parameters SHALL be applied as XOR on the registered pin values, including idle levels.
REQ-025 mode_i SHALL be sampled only at frame start; mid-frame changes SHALL take effect at the next frame.
REQ-026 Stream mode: a frame start with the holding register full SHALL load it and mark it empty; with it empty, SHALL reload the last streamed word (0 after reset) and pulse underflow_o for one cycle.
REQ-027 s_ready SHALL equal NOT holding-full; s_valid&s_ready SHALL capture s_data; non-stream modes SHALL NOT consume the holding register.
REQ-028 Fixed mode SHALL load pattern_i.
REQ-029 Ramp mode SHALL load the ramp counter, then increment it modulo 2^DATA_WIDTH; the counter SHALL change only on ramp-mode frames.
REQ-030 Checkerboard mode SHALL alternate 0xAAA, 0x555 (LSB-aligned for other widths), starting 0xAAA after reset.
REQ-031 busy_o SHALL be high exactly when state=RUN.

Reset
REQ-032 While rst=1, and immediately on assertion, all state SHALL clear: IDLE, b=0, shift=0, holding empty (s_ready=1), last word=0, ramp=0, checkerboard phase=0xAAA, frame_cnt_o=0, underflow_o=0, busy_o=0, din_o/dco_o/fco_o=0 before inversion.
REQ-033 A reset asserted mid-frame SHALL abandon the frame; the first frame after release SHALL start only on enable_i.

Verification
REQ-034 Stream mode: push 0xA5C and 0x123, enable -> din_o 101001011100 then 000100100011 contiguous; fco_o 6 high/6 low per frame; dco_o toggles every clk; frame_cnt_o=2.
REQ-035 Stream mode: one sample 0x800, enable for 2 frames -> second frame repeats 0x800; underflow_o pulses once at the second frame start.
REQ-036 Ramp mode from reset, 4097 frames -> words 0x000, 0x001, ... 0xFFF, then 0x000.
REQ-037 enable_i dropped at b=3 -> all 12 bits sent; busy_o low and pins 0 from the cycle after b=11.
REQ-038 rst pulsed at b=7 -> pins 0 immediately; s_ready=1; frame_cnt_o=0; no partial frame resumes.
REQ-039 DIN_INVERTED=1, fixed 0xFFF -> din_o idle 1 and 12 zeros per frame; dco_o/fco_o unaffected.
